// File: rtl/pipeline_sequencer_if.sv
// Sequencer <-> pipeline bundle: stall/decode inputs in, stage and control strobes out.
interface pipeline_sequencer_if #(
  parameter int unsigned GROUP_W  = 7,
  parameter int unsigned STAGE_W  = 5,
  parameter int unsigned SIGNAL_W = 6
);
  logic                stall;
  logic [GROUP_W-1:0]  opcode_group;
  logic                two_word;
  logic [STAGE_W-1:0]  pipeline_stage;
  logic                fetch_word;
  logic [SIGNAL_W-1:0] signals;
  logic                instr_done;

  // Sequencer side: consumes stall/decode, produces stage and strobes.
  modport master (
    input  stall, opcode_group, two_word,
    output pipeline_stage, fetch_word, signals, instr_done
  );

  // Pipeline side: the mirror view.
  modport slave (
    output stall, opcode_group, two_word,
    input  pipeline_stage, fetch_word, signals, instr_done
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: steps one instruction through IF->ID->EX->MEM->WB with
// memory wait states, a global stall and two-word fetch; emits stage-qualified strobes.
`ifndef PIPELINE_SEQUENCER_DEFS
`define PIPELINE_SEQUENCER_DEFS
`define GROUP_COUNT          7
`define GROUP_ALU            0
`define GROUP_ALU_TWO_OP     1
`define GROUP_LOAD           2
`define GROUP_LOAD_INDIRECT  3
`define GROUP_STORE          4
`define GROUP_STORE_INDIRECT 5
`define GROUP_REGISTER       6
`define STAGE_COUNT          5
`define STAGE_IF             5'b00001
`define STAGE_ID             5'b00010
`define STAGE_EX             5'b00100
`define STAGE_MEM            5'b01000
`define STAGE_WB             5'b10000
`define SIGNAL_COUNT         6
`define CONTROL_RR_READ      0
`define CONTROL_RD_READ      1
`define CONTROL_RR_WRITE     2
`define CONTROL_RD_WRITE     3
`define CONTROL_MEM_READ     4
`define CONTROL_MEM_WRITE    5
`endif

module pipeline_sequencer #(
  parameter int unsigned MEM_WAIT    = 2,
  parameter bit          TWO_WORD_EN = 1'b1,
  parameter int unsigned WAIT_W      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_sequencer_if.master bus
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

  typedef enum logic [`STAGE_COUNT-1:0] {
    ST_IF  = `STAGE_IF,
    ST_ID  = `STAGE_ID,
    ST_EX  = `STAGE_EX,
    ST_MEM = `STAGE_MEM,
    ST_WB  = `STAGE_WB
  } stage_e;

  stage_e                    stage_q, stage_d;
  logic                      fetch_q, fetch_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic [`GROUP_COUNT-1:0]   group_q, group_d;
  logic [`SIGNAL_COUNT-1:0]  strobes;
  logic                      done;
  logic                      mem_grp;
  logic [`GROUP_COUNT-1:0]   id_grp;
  logic                      unused_group;

  assign mem_grp = group_q[`GROUP_LOAD] | group_q[`GROUP_STORE];
  assign id_grp  = bus.opcode_group;

  // Latched group bits that no later stage decodes; kept whole for visibility.
  assign unused_group = ^{group_q[`GROUP_ALU_TWO_OP], group_q[`GROUP_LOAD_INDIRECT],
                          group_q[`GROUP_STORE_INDIRECT]};

  // State register: stage, fetch word, wait counter and latched group.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= ST_IF;
      fetch_q <= 1'b0;
      wait_q  <= '0;
      group_q <= '0;
    end else begin
      stage_q <= stage_d;
      fetch_q <= fetch_d;
      wait_q  <= wait_d;
      group_q <= group_d;
    end
  end

  // Next state and strobes; stall freezes all state, and the commit strobes
  // (RD_WRITE, MEM_WRITE, instr_done) wait for the released cycle so each fires once.
  always_comb begin
    stage_d = stage_q;
    fetch_d = fetch_q;
    wait_d  = wait_q;
    group_d = group_q;
    strobes = '0;
    done    = 1'b0;

    case (stage_q)
      ST_IF: begin
        if (!bus.stall) begin
          if (TWO_WORD_EN && bus.two_word && !fetch_q) begin
            fetch_d = 1'b1;
          end else begin
            stage_d = ST_ID;
            fetch_d = 1'b0;
          end
        end
      end
      ST_ID: begin
        strobes[`CONTROL_RR_READ] = id_grp[`GROUP_ALU_TWO_OP] | id_grp[`GROUP_LOAD_INDIRECT] |
                                    id_grp[`GROUP_REGISTER]   | id_grp[`GROUP_STORE];
        strobes[`CONTROL_RD_READ] = id_grp[`GROUP_ALU] | id_grp[`GROUP_STORE_INDIRECT] |
                                    id_grp[`GROUP_LOAD_INDIRECT];
        if (!bus.stall) begin
          stage_d = ST_EX;
          group_d = bus.opcode_group;
        end
      end
      ST_EX: begin
        if (!bus.stall) begin
          stage_d = ST_MEM;
          wait_d  = '0;
        end
      end
      ST_MEM: begin
        strobes[`CONTROL_MEM_READ]  = group_q[`GROUP_LOAD];
        strobes[`CONTROL_MEM_WRITE] = group_q[`GROUP_STORE] && (wait_q == WAIT_LAST) && !bus.stall;
        if (!bus.stall) begin
          if (mem_grp && (wait_q < WAIT_LAST)) begin
            wait_d = wait_q + WAIT_W'(1);
          end else begin
            stage_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        strobes[`CONTROL_RD_WRITE] = (group_q[`GROUP_ALU] | group_q[`GROUP_REGISTER] |
                                      group_q[`GROUP_LOAD]) & !bus.stall;
        done = !bus.stall;
        if (!bus.stall) begin
          stage_d = ST_IF;
        end
      end
      default: begin
        stage_d = ST_IF;
        fetch_d = 1'b0;
      end
    endcase
  end

  assign bus.pipeline_stage = stage_q;
  assign bus.fetch_word     = fetch_q;
  assign bus.signals        = strobes;
  assign bus.instr_done     = done;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized bench for pipeline_sequencer: instruction-level latency model in a
// scoreboard queue, per-cycle strobe table, monitor decoupled from the driver.
module tb_pipeline_sequencer;

  localparam int unsigned MEM_WAIT    = 2;
  localparam bit          TWO_WORD_EN = 1'b1;
  localparam int unsigned WAIT_W      = 2;

  localparam int G_ALU = 0, G_ALU2 = 1, G_LD = 2, G_LDI = 3, G_ST = 4, G_STI = 5, G_REG = 6;
  localparam logic [6:0] GR_ALU = 7'b0000001, GR_LD = 7'b0000100, GR_ST = 7'b0010000,
                         GR_REG = 7'b1000000, GR_LDI = 7'b0001000, GR_NONE = 7'b0000000;
  localparam logic [4:0] S_IF = 5'b00001, S_ID = 5'b00010, S_EX = 5'b00100,
                         S_MEM = 5'b01000, S_WB = 5'b10000;
  localparam int C_RRR = 0, C_RDR = 1, C_RRW = 2, C_RDW = 3, C_MR = 4, C_MW = 5;

  typedef struct {
    int         if_n;
    int         id_n;
    int         ex_n;
    int         mem_n;
    int         wb_n;
    int         fw_n;
    int         total;
    logic [6:0] grp;
  } rec_t;

  logic clk;
  logic reset;
  pipeline_sequencer_if bus ();

  pipeline_sequencer #(
    .MEM_WAIT   (MEM_WAIT),
    .TWO_WORD_EN(TWO_WORD_EN),
    .WAIT_W     (WAIT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  rec_t       sb_q[$];
  bit         mon_en = 1'b0;
  logic [6:0] cur_grp;
  int         stall_pct;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level expectation: cycles spent per stage when not stalled.
  function automatic rec_t model(input logic [6:0] g, input bit tw);
    rec_t r;
    bit   mem_op;
    bit   second;
    mem_op  = g[G_LD] | g[G_ST];
    second  = tw && TWO_WORD_EN;
    r.if_n  = second ? 2 : 1;
    r.fw_n  = second ? 1 : 0;
    r.id_n  = 1;
    r.ex_n  = 1;
    r.mem_n = mem_op ? 1 + int'(MEM_WAIT) : 1;
    r.wb_n  = 1;
    r.total = 5 + (mem_op ? int'(MEM_WAIT) : 0) + (second ? 1 : 0);
    r.grp   = g;
    return r;
  endfunction

  // Strobe table for one cycle; memk = unstalled MEM cycles already spent.
  function automatic logic [5:0] exp_sig(input logic [4:0] st, input logic [6:0] g,
                                         input bit stl, input int memk);
    logic [5:0] s;
    s = '0;
    if (st == S_ID) begin
      s[C_RRR] = g[G_ALU2] | g[G_LDI] | g[G_REG] | g[G_ST];
      s[C_RDR] = g[G_ALU] | g[G_STI] | g[G_LDI];
    end else if (st == S_MEM) begin
      s[C_MR] = g[G_LD];
      s[C_MW] = g[G_ST] && !stl && (memk == int'(MEM_WAIT));
    end else if (st == S_WB) begin
      s[C_RDW] = (g[G_ALU] | g[G_REG] | g[G_LD]) && !stl;
    end
    return s;
  endfunction

  function automatic logic [6:0] rand_group();
    int         k;
    logic [6:0] g;
    k = int'($urandom_range(7));
    g = '0;
    if (k < 7) g[k] = 1'b1;
    return g;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_stage"}, 32'(bus.pipeline_stage), 32'(S_IF));
    check({tag, "_fetch_word"}, 32'(bus.fetch_word), 32'd0);
    check({tag, "_signals"}, 32'(bus.signals), 32'd0);
    check({tag, "_instr_done"}, 32'(bus.instr_done), 32'd0);
  endtask

  // Monitor: per-cycle strobe check, per-instruction stage accounting on retire.
  rec_t obs;
  initial begin : monitor
    obs = '{default: 0};
    forever begin
      @(negedge clk);
      if (reset || !mon_en) begin
        obs = '{default: 0};
      end else begin : sample
        logic [6:0] g;
        rec_t       e;
        g = (sb_q.size() > 0) ? sb_q[0].grp : 7'd0;
        check("signals", 32'(bus.signals),
              32'(exp_sig(bus.pipeline_stage, g, bus.stall, obs.mem_n)));
        check("instr_done", 32'(bus.instr_done),
              32'((bus.pipeline_stage == S_WB) && !bus.stall));
        if (!bus.stall) begin
          obs.total++;
          case (bus.pipeline_stage)
            S_IF: begin
              obs.if_n++;
              if (bus.fetch_word) obs.fw_n++;
            end
            S_ID:  obs.id_n++;
            S_EX:  obs.ex_n++;
            S_MEM: obs.mem_n++;
            S_WB:  obs.wb_n++;
            default: check("stage_legal", 32'(bus.pipeline_stage), 32'(S_IF));
          endcase
        end
        if (bus.instr_done) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: instr_done with no instruction outstanding");
          end else begin
            e = sb_q.pop_front();
            check("if_cycles", 32'(obs.if_n), 32'(e.if_n));
            check("second_fetch", 32'(obs.fw_n), 32'(e.fw_n));
            check("id_cycles", 32'(obs.id_n), 32'(e.id_n));
            check("ex_cycles", 32'(obs.ex_n), 32'(e.ex_n));
            check("mem_cycles", 32'(obs.mem_n), 32'(e.mem_n));
            check("wb_cycles", 32'(obs.wb_n), 32'(e.wb_n));
            check("latency", 32'(obs.total), 32'(e.total));
          end
          obs = '{default: 0};
        end
      end
    end
  end

  // Drives stall and a group that is only meaningful during ID.
  task automatic drive_cycle();
    bus.stall        = (int'($urandom_range(99)) < stall_pct);
    bus.opcode_group = (bus.pipeline_stage == S_ID) ? cur_grp : 7'($urandom);
  endtask

  task automatic run_instr(input logic [6:0] g, input bit tw);
    bit done;
    done = 1'b0;
    sb_q.push_back(model(g, tw));
    cur_grp      = g;
    bus.two_word = tw;
    drive_cycle();
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (bus.instr_done) done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) drive_cycle();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: group %0h not retired within 200 cycles", g);
    end
  endtask

  initial begin : main
    int n;
    reset            = 1'b0;
    bus.stall        = 1'b0;
    bus.two_word     = 1'b0;
    bus.opcode_group = '0;
    cur_grp          = '0;
    stall_pct        = 0;
    #1 reset = 1'b1;
    #2;
    check_reset_state("por");
    repeat (3) begin
      @(negedge clk);
      check_reset_state("por_hold");
    end
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Directed: plain ALU, load, store, register, two-word and empty group.
    run_instr(GR_ALU, 1'b0);
    run_instr(GR_LD, 1'b0);
    run_instr(GR_ST, 1'b0);
    run_instr(GR_REG, 1'b0);
    run_instr(GR_ALU, 1'b1);
    run_instr(GR_ST, 1'b1);
    run_instr(GR_NONE, 1'b0);
    stall_pct = 50;
    run_instr(GR_ST, 1'b0);
    run_instr(GR_ALU, 1'b0);
    run_instr(GR_LDI, 1'b1);

    // Random mix with stalls.
    stall_pct = 30;
    for (int i = 0; i < 150; i++) run_instr(rand_group(), 1'($urandom_range(1)));

    // Reset in the store's last MEM cycle aborts the write at once.
    mon_en           = 1'b0;
    stall_pct        = 0;
    cur_grp          = GR_ST;
    bus.two_word     = 1'b0;
    bus.stall        = 1'b0;
    bus.opcode_group = GR_ST;
    n = 0;
    while (bus.pipeline_stage != S_MEM && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_mem", 32'(bus.pipeline_stage), 32'(S_MEM));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("store_write_before_reset", 32'(bus.signals[C_MW]), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_state("mid_mem");
    repeat (3) begin
      @(negedge clk);
      check_reset_state("mid_mem_hold");
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    mon_en = 1'b1;

    stall_pct = 25;
    for (int i = 0; i < 30; i++) run_instr(rand_group(), 1'($urandom_range(1)));

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
